// File: rtl/line_clear_ctrl_pkg.sv
// Shared types and constants for the playfield line-clear sequencer.
// Board geometry, cell colours, row type and controller states.
package line_clear_ctrl_pkg;

    localparam int X_SIZE    = 10;
    localparam int Y_SIZE    = 20;
    localparam int CELL_W    = 3;
    localparam int ROW_W     = CELL_W * X_SIZE;
    localparam int ROW_IDX_W = 5;

    localparam logic [ROW_IDX_W-1:0] LAST_ROW  = ROW_IDX_W'(Y_SIZE - 1);
    localparam logic [ROW_W-1:0]     EMPTY_ROW = '0;

    typedef enum logic [CELL_W-1:0] {
        EMPTY  = 3'd0,
        CYAN   = 3'd1,
        BLUE   = 3'd2,
        ORANGE = 3'd3,
        YELLOW = 3'd4,
        GREEN  = 3'd5,
        PURPLE = 3'd6,
        RED    = 3'd7
    } block_color;

    typedef block_color [X_SIZE-1:0] board_row;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WRITE,
        FILL,
        DONE
    } clr_state;

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row detector: a row is full when no cell is EMPTY.
module row_full_detect
    import line_clear_ctrl_pkg::*;
(
    input  board_row i_row,
    output logic     o_full
);

    always_comb begin
        // NOTE: default assigned first so the loop cannot infer a latch.
        o_full = 1'b1;
        for (int i = 0; i < X_SIZE; i++) begin
            if (i_row[i] == EMPTY) begin
                o_full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans rows bottom-up, drops full rows, compacts the
// survivors downward through the board write port and back-fills the top.
module line_clear_ctrl
    import line_clear_ctrl_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic [ROW_IDX_W-1:0] o_rd_row,
    input  logic [ROW_W-1:0]     i_rd_data,
    output logic                 o_wr_en,
    output logic [ROW_IDX_W-1:0] o_wr_row,
    output logic [ROW_W-1:0]     o_wr_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ROW_IDX_W-1:0] o_lines_cleared
);

    clr_state             r_state;
    logic [ROW_IDX_W-1:0] r_rd_ptr;
    logic [ROW_IDX_W-1:0] r_wr_ptr;
    logic [ROW_IDX_W-1:0] r_count;
    logic [ROW_IDX_W-1:0] r_rd_hold;
    logic [ROW_IDX_W-1:0] r_lines_cleared;
    board_row             r_row_buf;

    clr_state             w_state_nxt;
    logic [ROW_IDX_W-1:0] w_rd_ptr_nxt;
    logic [ROW_IDX_W-1:0] w_wr_ptr_nxt;
    logic [ROW_IDX_W-1:0] w_count_nxt;
    logic                 w_rd_full;

    row_full_detect u_row_full_detect (
        .i_row  (board_row'(i_rd_data)),
        .o_full (w_rd_full)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_rd_ptr        <= LAST_ROW;
            r_wr_ptr        <= LAST_ROW;
            r_count         <= '0;
            r_rd_hold       <= '0;
            r_lines_cleared <= '0;
            r_row_buf       <= board_row'(EMPTY_ROW);
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_state  <= w_state_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            if (r_state == READ) begin
                r_rd_hold <= r_rd_ptr;
            end
            if (r_state == CHECK) begin
                r_row_buf <= board_row'(i_rd_data);
            end
            if (r_state == DONE) begin
                r_lines_cleared <= r_count;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        o_wr_en      = 1'b0;
        o_wr_row     = '0;
        o_wr_data    = EMPTY_ROW;
        o_done       = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_rd_ptr_nxt = LAST_ROW;
                    w_wr_ptr_nxt = LAST_ROW;
                    w_count_nxt  = '0;
                    w_state_nxt  = READ;
                end
            end

            READ: begin
                w_state_nxt = CHECK;
            end

            CHECK: begin
                if (w_rd_full) begin
                    w_count_nxt = r_count + 5'd1;
                    if (r_rd_ptr == '0) begin
                        w_state_nxt = FILL;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr - 5'd1;
                        w_state_nxt  = READ;
                    end
                end else begin
                    w_state_nxt = WRITE;
                end
            end

            WRITE: begin
                // A row that has not moved needs no rewrite.
                if (r_wr_ptr != r_rd_ptr) begin
                    o_wr_en   = 1'b1;
                    o_wr_row  = r_wr_ptr;
                    o_wr_data = r_row_buf;
                end
                w_wr_ptr_nxt = r_wr_ptr - 5'd1;
                if (r_rd_ptr == '0) begin
                    w_state_nxt = (r_count == '0) ? DONE : FILL;
                end else begin
                    w_rd_ptr_nxt = r_rd_ptr - 5'd1;
                    w_state_nxt  = READ;
                end
            end

            FILL: begin
                if (r_count == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    o_wr_en      = 1'b1;
                    o_wr_row     = r_wr_ptr;
                    o_wr_data    = EMPTY_ROW;
                    w_wr_ptr_nxt = r_wr_ptr - 5'd1;
                    if (r_wr_ptr == '0) begin
                        w_state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The read address is live in READ so data returns in CHECK.
    assign o_rd_row        = (r_state == READ) ? r_rd_ptr : r_rd_hold;
    assign o_busy          = (r_state != IDLE);
    assign o_lines_cleared = (r_state == DONE) ? r_count : r_lines_cleared;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: synchronous board model, write scoreboard,
// per-pass result queue and final board comparison.
module tb_line_clear_ctrl;
    import line_clear_ctrl_pkg::*;

    typedef struct packed {
        logic [ROW_IDX_W-1:0] row;
        logic [ROW_W-1:0]     data;
    } wr_t;

    typedef struct packed {
        int lines;
        int cycles;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ROW_IDX_W-1:0] rd_row;
    logic [ROW_W-1:0]     rd_data;
    logic                 wr_en;
    logic [ROW_IDX_W-1:0] wr_row;
    logic [ROW_W-1:0]     wr_data;
    logic                 busy;
    logic                 done;
    logic [ROW_IDX_W-1:0] lines_cleared;

    logic [ROW_W-1:0] board     [Y_SIZE];
    logic [ROW_W-1:0] exp_board [Y_SIZE];
    wr_t              exp_wr_q  [$];
    res_t             exp_res_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    line_clear_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .o_rd_row        (rd_row),
        .i_rd_data       (rd_data),
        .o_wr_en         (wr_en),
        .o_wr_row        (wr_row),
        .o_wr_data       (wr_data),
        .o_busy          (busy),
        .o_done          (done),
        .o_lines_cleared (lines_cleared)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= board[rd_row];
        if (wr_en) board[wr_row] <= wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_wr_q.size() == 0) begin
                check("wr_expected", 32'(wr_row), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                check("wr_row", 32'(wr_row), 32'(e.row));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        if (done) done_cnt++;
    end

    function automatic bit row_full(input logic [ROW_W-1:0] d);
        for (int i = 0; i < X_SIZE; i++) begin
            if (d[CELL_W*i +: CELL_W] == 3'(EMPTY)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [ROW_W-1:0] pat(input int seed, input bit full);
        logic [ROW_W-1:0] d;
        for (int i = 0; i < X_SIZE; i++) d[CELL_W*i +: CELL_W] = 3'((seed + i) % 7 + 1);
        if (!full) d[CELL_W*(seed % X_SIZE) +: CELL_W] = 3'(EMPTY);
        return d;
    endfunction

    // Reference compaction: keep non-full rows in order, packed to the bottom.
    task automatic plan_pass();
        int dst = Y_SIZE - 1;
        int cnt = 0;
        int cyc = 1;
        for (int i = 0; i < Y_SIZE; i++) exp_board[i] = EMPTY_ROW;
        for (int src = Y_SIZE - 1; src >= 0; src--) begin
            if (row_full(board[src])) begin
                cnt++;
                cyc += 2;
            end else begin
                cyc += 3;
                if (dst != src) exp_wr_q.push_back('{row: ROW_IDX_W'(dst), data: board[src]});
                exp_board[dst] = board[src];
                dst--;
            end
        end
        for (int k = dst; k >= 0; k--) exp_wr_q.push_back('{row: ROW_IDX_W'(k), data: EMPTY_ROW});
        cyc += cnt;
        exp_res_q.push_back('{lines: cnt, cycles: cyc});
    endtask

    task automatic run_pass(input int extra_start_cyc, input bit start_at_done);
        int   cyc  = 0;
        bit   seen = 1'b0;
        res_t r;
        plan_pass();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_start_cyc);
            if (cyc == 1) check("busy_rise", 32'(busy), 32'd1);
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        r = exp_res_q.pop_front();
        check("latency", 32'(cyc), 32'(r.cycles));
        check("busy_at_done", 32'(busy), 32'd1);
        check("lines_at_done", 32'(lines_cleared), 32'(r.lines));
        start = start_at_done;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        check("lines_held", 32'(lines_cleared), 32'(r.lines));
        repeat (3) @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
        for (int i = 0; i < Y_SIZE; i++) begin
            check($sformatf("board_row%0d", i), 32'(board[i]), 32'(exp_board[i]));
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < Y_SIZE; i++) board[i] = EMPTY_ROW;
    endtask

    initial begin
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        clear_board();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_lines", 32'(lines_cleared), 32'd0);
        check("rst_rd_row", 32'(rd_row), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // No full rows: one CYAN cell per row, no writes, 61-cycle pass.
        for (int i = 0; i < Y_SIZE; i++) board[i] = {{(ROW_W-CELL_W){1'b0}}, 3'(CYAN)};
        run_pass(0, 1'b0);

        // Single full bottom row with pattern above it.
        clear_board();
        board[19] = pat(3, 1'b1);
        board[18] = pat(5, 1'b0);
        run_pass(0, 1'b0);

        // Tetris: bottom four rows full, distinct patterns above.
        for (int i = 0; i < 16; i++) board[i] = pat(i + 1, 1'b0);
        for (int i = 16; i < 20; i++) board[i] = pat(i, 1'b1);
        run_pass(0, 1'b0);

        // Non-contiguous full rows 19 and 17.
        clear_board();
        board[19] = pat(2, 1'b1);
        board[18] = pat(7, 1'b0);
        board[17] = pat(4, 1'b1);
        board[16] = pat(9, 1'b0);
        run_pass(0, 1'b0);

        // Random board; extra start at cycle 10 and in the done cycle.
        for (int i = 0; i < Y_SIZE; i++) board[i] = pat(int'($urandom_range(0, 50)), ($urandom_range(0, 2) == 0));
        run_pass(10, 1'b1);

        // Reset mid-pass while a compaction write is in flight.
        clear_board();
        board[19] = pat(1, 1'b1);
        for (int i = 0; i < 19; i++) board[i] = pat(i + 20, 1'b0);
        plan_pass();
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_lines", 32'(lines_cleared), 32'd0);
        exp_wr_q.delete();
        exp_res_q.delete();
        @(negedge clk);
        rst = 1'b0;
        board[19] = pat(1, 1'b1);
        for (int i = 0; i < 19; i++) board[i] = pat(i + 20, 1'b0);
        run_pass(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
